dl_ram_arbiter: RTL
===================

DL_RAM_ARBITER -- requirements
Module: dl_ram_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2; sets the depth of the download write buffer in entries.
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port dl_active, input, 1: download in progress (level, already in clk domain).
REQ-005 SHALL have port dl_wr, input, 1: one-cycle write strobe from the download path.
REQ-006 SHALL have ports dl_addr (input, 25) and dl_data (input, 16): word address and data, valid when dl_wr=1.
REQ-007 SHALL have port dl_overflow, output, 1: sticky flag, a download write was dropped.
REQ-008 SHALL have port dl_done, output, 1: one-cycle pulse when a download has fully drained to RAM.
REQ-009 SHALL have ports cpu_req (input, 1), cpu_we (input, 1), cpu_addr (input, 25) and cpu_din (input, 16): CPU access request; inputs held stable while cpu_req=1.
REQ-010 SHALL have ports cpu_dout (output, 16) and cpu_ack (output, 1): CPU read data, and a one-cycle completion pulse.
REQ-011 SHALL have ports ram_req, ram_we (outputs, 1), ram_addr (output, 25) and ram_din (output, 16): shared RAM port request.
REQ-012 SHALL have ports ram_dout (input, 16) and ram_ack (input, 1): RAM read data, and a one-cycle completion strobe.

Function
REQ-013 SHALL push {dl_addr, dl_data} into the FIFO on every clk edge where dl_wr=1 and the FIFO is not full.
REQ-014 SHALL, on dl_wr=1 with the FIFO full, drop the write and set dl_overflow=1.
REQ-015 SHALL keep dl_overflow set until the rising edge of dl_active, where it clears.
REQ-016 SHALL, on a simultaneous push and pop, leave the occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 SHALL implement FSM states IDLE, DL_WR, CPU_ACC and CPU_REL.
REQ-018 SHALL, in IDLE with the FIFO non-empty, drive ram_req=1, ram_we=1, ram_addr/ram_din = FIFO head on the next edge, and go to DL_WR.
REQ-019 SHALL, in IDLE with the FIFO empty, dl_active=0 and cpu_req=1, drive ram_req=1, ram_we=cpu_we, ram_addr=cpu_addr, ram_din=cpu_din, and go to CPU_ACC.
REQ-020 SHALL give the FIFO absolute priority over the CPU; the CPU SHALL never be granted while dl_active=1.
REQ-021 SHALL hold ram_req, ram_we, ram_addr and ram_din stable in DL_WR and CPU_ACC until ram_ack=1.
REQ-022 SHALL, on ram_ack in DL_WR: clear ram_req and ram_we, pop the FIFO, and go to IDLE (same edge).
REQ-023 SHALL, on ram_ack in CPU_ACC: clear ram_req and ram_we, register cpu_dout<=ram_dout (reads only; unchanged on writes), pulse cpu_ack for exactly one cycle, and go to CPU_REL.
REQ-024 SHALL, in CPU_REL, wait for cpu_req=0, then go to IDLE; a held cpu_req is never serviced twice.
REQ-025 SHALL ignore ram_ack in IDLE and CPU_REL.
REQ-026 SHALL pulse dl_done for one cycle on the first cycle meeting all of: dl_active=0, FIFO empty, state≠DL_WR, and at least one dl_active=1 cycle since the last dl_done or reset.
REQ-027 SHALL make the minimum dl_wr-to-ram_req latency 2 cycles with an empty FIFO and state IDLE.

Reset
REQ-028 SHALL, on reset_n=0 (asynchronous, including mid-access), force: state IDLE, FIFO empty, ram_req=0, ram_we=0, ram_addr=0, ram_din=0, cpu_ack=0, cpu_dout=0, dl_overflow=0, dl_done=0, download-seen flag cleared.
REQ-029 SHALL leave an in-flight RAM access abandoned after reset; a late ram_ack is ignored per REQ-025.

Verification
REQ-030 SHALL cover: dl_active=1, dl_wr at addr 0x000000 data 0x1234, ram_ack 3 cycles after ram_req -> ram_req rises 2 cycles after dl_wr, ram_we=1, ram_addr=0, ram_din=0x1234, held until ack.
REQ-031 SHALL cover: FIFO_DEPTH=4, ram_ack withheld, 5 dl_wr -> 4 entries buffered, dl_overflow=1; after acks, exactly 4 RAM writes in order; next dl_active rise clears dl_overflow.
REQ-032 SHALL cover: dl_active=0, cpu_req read of 0x0000100, ram_dout=0xBEEF at ram_ack -> cpu_ack one cycle, cpu_dout=0xBEEF, cpu_req held 5 more cycles -> no second ram_req.
REQ-033 SHALL cover: cpu_req=1 while dl_active=1 with 2 queued writes -> both writes issued, CPU granted only after dl_active=0; dl_done pulses once, before the CPU ram_req.
REQ-034 SHALL cover: reset_n=0 during DL_WR with 3 entries -> ram_req=0 immediately, FIFO empty, a subsequent ram_ack produces no pop and no cpu_ack.
REQ-035 SHALL cover: dl_wr coincident with ram_ack pop at occupancy 4 of 4 -> accepted, occupancy stays 4, no overflow.

Source files
------------

// File: rtl/dl_ram_arbiter.sv
// Shares one RAM port between a buffered download write stream and a single
// outstanding CPU access. Buffered download writes always take precedence.
module dl_ram_arbiter #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dl_active,
   input  logic        dl_wr,
   input  logic [24:0] dl_addr,
   input  logic [15:0] dl_data,
   output logic        dl_overflow,
   output logic        dl_done,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [24:0] cpu_addr,
   input  logic [15:0] cpu_din,
   output logic [15:0] cpu_dout,
   output logic        cpu_ack,
   output logic        ram_req,
   output logic        ram_we,
   output logic [24:0] ram_addr,
   output logic [15:0] ram_din,
   input  logic [15:0] ram_dout,
   input  logic        ram_ack
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DL_WR   = 2'd1,
      CPU_ACC = 2'd2,
      CPU_REL = 2'd3
   } state_t;

   logic [40:0]   r_fifoMem [FIFO_DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;

   state_t        r_state;
   logic          r_ramReq;
   logic          r_ramWe;
   logic [24:0]   r_ramAddr;
   logic [15:0]   r_ramDin;
   logic          r_cpuAck;
   logic [15:0]   r_cpuDout;
   logic          r_dlOverflow;
   logic          r_dlDone;
   logic          r_dlSeen;
   logic          r_dlActiveD;

   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic          w_dlRise;
   logic          w_doneCond;
   logic          w_cpuGrant;
   logic [40:0]   w_head;

   // A pop on the same edge frees a slot, so a write arriving at full is kept.
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == DEPTH_C);
   assign w_pop      = (r_state == DL_WR) && ram_ack;
   assign w_push     = dl_wr && (!w_full || w_pop);
   assign w_drop     = dl_wr && w_full && !w_pop;
   assign w_dlRise   = dl_active && !r_dlActiveD;
   assign w_head     = r_fifoMem[r_rdPtr];
   assign w_doneCond = !dl_active && w_empty && (r_state != DL_WR) && r_dlSeen;

   // The CPU waits one extra cycle after a download so dl_done is seen first.
   assign w_cpuGrant = cpu_req && w_empty && !dl_active && !r_dlSeen;

   assign ram_req     = r_ramReq;
   assign ram_we      = r_ramWe;
   assign ram_addr    = r_ramAddr;
   assign ram_din     = r_ramDin;
   assign cpu_ack     = r_cpuAck;
   assign cpu_dout    = r_cpuDout;
   assign dl_overflow = r_dlOverflow;
   assign dl_done     = r_dlDone;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifoMem[r_wrPtr] <= {dl_addr, dl_data};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // A drop on the same edge as a new download start still leaves the flag set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dlOverflow <= 1'b0;
         r_dlDone     <= 1'b0;
         r_dlSeen     <= 1'b0;
         r_dlActiveD  <= 1'b0;
      end else begin
         r_dlActiveD <= dl_active;
         r_dlDone    <= w_doneCond;
         if (w_drop) begin
            r_dlOverflow <= 1'b1;
         end else if (w_dlRise) begin
            r_dlOverflow <= 1'b0;
         end
         if (w_doneCond) begin
            r_dlSeen <= 1'b0;
         end else if (dl_active) begin
            r_dlSeen <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_ramReq  <= 1'b0;
         r_ramWe   <= 1'b0;
         r_ramAddr <= '0;
         r_ramDin  <= '0;
         r_cpuAck  <= 1'b0;
         r_cpuDout <= '0;
      end else begin
         r_cpuAck <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_ramReq  <= 1'b1;
                  r_ramWe   <= 1'b1;
                  r_ramAddr <= w_head[40:16];
                  r_ramDin  <= w_head[15:0];
                  r_state   <= DL_WR;
               end else if (w_cpuGrant) begin
                  r_ramReq  <= 1'b1;
                  r_ramWe   <= cpu_we;
                  r_ramAddr <= cpu_addr;
                  r_ramDin  <= cpu_din;
                  r_state   <= CPU_ACC;
               end
            end
            DL_WR: begin
               if (ram_ack) begin
                  r_ramReq <= 1'b0;
                  r_ramWe  <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            CPU_ACC: begin
               if (ram_ack) begin
                  r_ramReq <= 1'b0;
                  r_ramWe  <= 1'b0;
                  if (!r_ramWe) begin
                     r_cpuDout <= ram_dout;
                  end
                  r_cpuAck <= 1'b1;
                  r_state  <= CPU_REL;
               end
            end
            CPU_REL: begin
               if (!cpu_req) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
